// File: rtl/pipeline_ctrl_if.sv
// Pipeline hazard/redirect control bus between the datapath and pipeline_ctrl.
interface pipeline_ctrl_if;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        ex_div_instr;
  logic        div_busy;
  logic        div_finished;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        trap_req;
  logic [31:0] trap_pc;
  logic        halt_req;
  logic        stall_if;
  logic        stall_id;
  logic        stall_ex;
  logic        bubble_ex;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [31:0] stall_cycles;

  // Datapath side: reports hazards/events, consumes stall/flush/redirect controls.
  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_is_load, ex_rd, ex_div_instr, div_busy, div_finished,
           branch_taken, branch_target, trap_req, trap_pc, halt_req,
    input  stall_if, stall_id, stall_ex, bubble_ex, flush_if_id, flush_id_ex,
           pc_redirect, redirect_pc, halted, stall_cycles
  );

  // Controller side.
  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_is_load, ex_rd, ex_div_instr, div_busy, div_finished,
           branch_taken, branch_target, trap_req, trap_pc, halt_req,
    output stall_if, stall_id, stall_ex, bubble_ex, flush_if_id, flush_id_ex,
           pc_redirect, redirect_pc, halted, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: load-use interlock, divider wait, branch/trap redirect
// with one-cycle flush, halt, and a stall-cycle performance counter.
module pipeline_ctrl (
  input  logic              clk,
  input  logic              reset,
  pipeline_ctrl_if.slave    bus
);
  typedef enum logic [1:0] {RUN, DIV_WAIT, REDIRECT, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [31:0] cnt_q;
  logic        load_use;
  logic        s_if, s_id, s_ex, bub, f_ifid, f_idex, redir, hlt;

  // Load-use hazard; x0 is never a real dependency.
  assign load_use = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                    ((bus.id_uses_rs1 && (bus.ex_rd == bus.id_rs1_addr)) ||
                     (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2_addr)));

  // Next-state, target capture and combinational control outputs.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    s_if     = 1'b0;
    s_id     = 1'b0;
    s_ex     = 1'b0;
    bub      = 1'b0;
    f_ifid   = 1'b0;
    f_idex   = 1'b0;
    redir    = 1'b0;
    hlt      = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.trap_req) begin
          target_d = bus.trap_pc;
          state_d  = REDIRECT;
        end else if (bus.branch_taken) begin
          target_d = bus.branch_target;
          state_d  = REDIRECT;
        end else if (bus.halt_req) begin
          state_d = HALTED;
        end else if (bus.ex_div_instr && !bus.div_finished) begin
          s_if    = 1'b1;
          s_id    = 1'b1;
          s_ex    = 1'b1;
          state_d = DIV_WAIT;
        end else if (load_use) begin
          s_if = 1'b1;
          s_id = 1'b1;
          bub  = 1'b1;
        end
      end
      DIV_WAIT: begin
        // A trap abandons the divide; the trapped instruction is squashed.
        if (bus.trap_req) begin
          target_d = bus.trap_pc;
          state_d  = REDIRECT;
        end else if (!bus.div_finished) begin
          s_if = 1'b1;
          s_id = 1'b1;
          s_ex = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      REDIRECT: begin
        redir  = 1'b1;
        f_ifid = 1'b1;
        f_idex = 1'b1;
        // Younger branch/halt/load-use are wrong-path; only a trap wins.
        if (bus.trap_req) target_d = bus.trap_pc;
        else              state_d  = RUN;
      end
      HALTED: begin
        hlt  = 1'b1;
        s_if = 1'b1;
        s_id = 1'b1;
        s_ex = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (reset) begin
      state_d  = RUN;
      target_d = '0;
      s_if     = 1'b0;
      s_id     = 1'b0;
      s_ex     = 1'b0;
      bub      = 1'b0;
      f_ifid   = 1'b0;
      f_idex   = 1'b0;
      redir    = 1'b0;
      hlt      = 1'b0;
    end
  end

  // State, captured target and stall counter (counter wraps naturally).
  always_ff @(posedge clk) begin
    state_q  <= state_d;
    target_q <= target_d;
    if (reset)     cnt_q <= '0;
    else if (s_if) cnt_q <= cnt_q + 32'd1;
  end

  assign bus.stall_if     = s_if;
  assign bus.stall_id     = s_id;
  assign bus.stall_ex     = s_ex;
  assign bus.bubble_ex    = bub;
  assign bus.flush_if_id  = f_ifid;
  assign bus.flush_id_ex  = f_idex;
  assign bus.pc_redirect  = redir;
  assign bus.halted       = hlt;
  assign bus.redirect_pc  = reset ? 32'd0 : target_q;
  assign bus.stall_cycles = reset ? 32'd0 : cnt_q;

  // div_busy is informational; the divide wait is keyed on div_finished.
  logic unused_ok;
  assign unused_ok = bus.div_busy;
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1; reset is synchronous and active-high.
REQ-003 SHALL have port id_rs1_addr  in  5  rs1 of the instruction in ID.
REQ-004 SHALL have port id_rs2_addr  in  5  rs2 of the instruction in ID.
REQ-005 SHALL have port id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1/rs2.
REQ-006 SHALL have port ex_is_load  in  1  and ex_rd  in  5; these give the load instruction in EX and its destination.
REQ-007 SHALL have port ex_div_instr  in  1, div_busy  in  1 and div_finished  in  1; these give the divider status in EX.
REQ-008 SHALL have port branch_taken  in  1  and branch_target  in  32; these give the EX jump or taken branch and its target.
REQ-009 SHALL have port trap_req  in  1  and trap_pc  in  32; these give a CSR trap or mret redirect and its target.
REQ-010 SHALL have port halt_req  in  1  for a decoded halt instruction.
REQ-011 SHALL have output stall_if, stall_id and stall_ex  out  1 each; these hold PC, IF/ID and ID/EX respectively.
REQ-012 SHALL have output bubble_ex  out  1  to load a NOP into ID/EX.
REQ-013 SHALL have output flush_if_id and flush_id_ex  out  1 each  to squash wrong-path instructions.
REQ-014 SHALL have output pc_redirect  out  1  and redirect_pc  out  32  to load the PC.
REQ-015 SHALL have output halted  out  1  and stall_cycles  out  32  (performance counter).

Function
REQ-016 SHALL implement a registered FSM with states RUN, DIV_WAIT, REDIRECT and HALTED; outputs are combinational from the state and inputs.
REQ-017 SHALL use this priority in RUN: trap_req, then branch_taken, then halt_req, then divide, then load-use, then normal.
REQ-018 SHALL detect load-use in RUN as ex_is_load and ex_rd!=0 and ((id_uses_rs1 and ex_rd==id_rs1_addr) or (id_uses_rs2 and ex_rd==id_rs2_addr)).
REQ-019 SHALL respond to load-use in the same cycle with stall_if=stall_id=bubble_ex=1; this lasts exactly one cycle and the state stays RUN.
REQ-020 SHALL respond in RUN to ex_div_instr=1 and div_finished=0 with stall_if=stall_id=stall_ex=1 and next state DIV_WAIT.
REQ-021 SHALL hold all three stalls in DIV_WAIT while div_finished=0.
REQ-022 SHALL, in the cycle div_finished=1 in DIV_WAIT, drop all stalls and take next state RUN.
REQ-023 SHALL not stall when ex_div_instr=1 and div_finished=1 occur together in RUN.
REQ-024 SHALL, on trap_req or branch_taken in RUN, capture the target (trap_pc or branch_target) in an internal register and take next state REDIRECT.
REQ-025 SHALL drive pc_redirect=1, redirect_pc=the captured target, flush_if_id=1 and flush_id_ex=1 for exactly one cycle in REDIRECT, then take next state RUN.
REQ-026 SHALL, in REDIRECT, ignore branch_taken, halt_req and load-use; it honours only trap_req, which recaptures trap_pc and stays in REDIRECT.
REQ-027 SHALL, on trap_req in DIV_WAIT, abandon the wait, capture trap_pc and take next state REDIRECT.
REQ-028 SHALL, on halt_req in RUN with no higher-priority event, take next state HALTED.
REQ-029 SHALL assert halted=1 and stall_if=stall_id=stall_ex=1 in HALTED; only reset leaves HALTED.
REQ-030 SHALL increment stall_cycles by 1 in each cycle that stall_if=1; the count wraps from 0xFFFFFFFF to 0.
REQ-031 SHALL hold redirect_pc at the last captured target when pc_redirect=0.

Reset
REQ-032 SHALL, while reset=1, set state RUN, all 1-bit outputs 0, redirect_pc=0 and stall_cycles=0.
REQ-033 SHALL, when reset is asserted mid-DIV_WAIT, mid-REDIRECT or in HALTED, take RUN on the next edge with no residual pc_redirect or flush.

Verification
REQ-034 SHALL cover load-use: ex_is_load=1, ex_rd=5, id_rs2_addr=5, id_uses_rs2=1 -> one cycle with stall_if=stall_id=bubble_ex=1 and stall_cycles going 0 to 1.
REQ-035 SHALL cover the x0 case: the load-use stimulus of REQ-034 with ex_rd=0 -> no stall.
REQ-036 SHALL cover divide: ex_div_instr=1 with div_finished rising 33 cycles later -> 33 stall cycles, stalls low in the finish cycle, stall_cycles=33.
REQ-037 SHALL cover branch: branch_taken=1, branch_target=0x00000040 -> next cycle pc_redirect=1, redirect_pc=0x40, both flushes=1, then RUN.
REQ-038 SHALL cover a simultaneous event: trap_req=1 with trap_pc=0x100 and branch_taken=1 with branch_target=0x40 -> redirect_pc=0x100.
REQ-039 SHALL cover halt: halt_req=1 -> halted=1 held for 10 cycles with stall_cycles reaching 10, then reset=1 -> all outputs 0 on the next edge.
